instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters SHALL be: NB_DATA 32, data/PC width; NB_MEM_ADDRESS 8, instruction memory word-index width (256 words).
REQ-002 i_clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_enable  input  1  run/step enable from debug unit; 0 freezes all fetch state.
REQ-005 i_stall  input  1  load-use hazard stall from ID; holds PC and IF/ID.
REQ-006 i_jump_o_branch  input  1  redirect request resolved in ID.
REQ-007 i_pc_destino  input  NB_DATA  redirect target byte address.
REQ-008 i_mem_write_enable  input  1  program loader write strobe.
REQ-009 i_mem_write_address  input  NB_MEM_ADDRESS  loader word index.
REQ-010 i_mem_write_data  input  NB_DATA  loader instruction word.
REQ-011 o_instruccion  output  NB_DATA  IF/ID instruction register, feeds ID decode.
REQ-012 o_pc_mas_4  output  NB_DATA  IF/ID copy of fetched PC+4, feeds ID return-address input.
REQ-013 o_pc  output  NB_DATA  current PC, for debug.
REQ-014 o_halt  output  1  high while FSM is in HALTED.

Function
REQ-015 PC SHALL be a byte address; memory word index SHALL be PC[NB_MEM_ADDRESS+1:2]; PC[1:0] ignored; index wraps modulo 256.
REQ-016 Memory read SHALL be combinational on the index; IF/ID SHALL capture it on the edge, giving one-cycle latency from PC to o_instruccion.
REQ-017 FSM states SHALL be RUN and HALTED; RUN->HALTED on a normal advance that captures HALT_WORD; HALTED exits only via reset.
REQ-018 Per-edge priority SHALL be: i_enable=0 (hold all) > HALTED > i_stall > i_jump_o_branch > normal advance.
REQ-019 Normal advance (RUN): PC <= PC+4 (wraps modulo 2^32); o_instruccion <= mem[index]; o_pc_mas_4 <= PC+4.
REQ-020 Stall: PC, o_instruccion, o_pc_mas_4 SHALL hold; a simultaneous redirect SHALL be ignored that cycle (ID re-presents it).
REQ-021 Redirect: PC <= i_pc_destino; o_instruccion <= NOP_WORD; o_pc_mas_4 <= 0; no HALT detection on that edge.
REQ-022 On entering HALTED, PC SHALL hold at the HALT address; o_instruccion SHALL contain HALT_WORD for that cycle.
REQ-023 In HALTED with i_enable=1, o_instruccion SHALL load NOP_WORD each edge so HALT drains downstream; PC holds; stall/redirect ignored.
REQ-024 Loader writes SHALL take effect on the edge only when i_mem_write_enable=1 and i_enable=0; writes with i_enable=1 SHALL be dropped.
REQ-025 A write and read of the same index in one cycle cannot occur (REQ-024); memory contents SHALL NOT be cleared by reset.
REQ-026 o_pc SHALL equal the PC register; o_halt SHALL be a registered state decode, no combinational path from inputs.

Reset
REQ-027 While i_reset=0: PC=0, o_instruccion=NOP_WORD, o_pc_mas_4=0, FSM=RUN, o_halt=0, applied asynchronously.
REQ-028 Reset deassertion mid-operation SHALL resume fetch from address 0 on the first enabled edge.

Structure
REQ-029 A shared package SHALL hold NOP_WORD (32'h00000000), HALT_WORD (32'hFC000000, op field 6'b111111), PC_INCREMENT (4), and FSM state encodings.
REQ-030 The memory array SHALL be a sub-module instruction_memory (one sync write port, one async read port); PC, IF/ID and FSM SHALL stay in instruction_fetch.

Verification
REQ-031 Load mem[0..2]={32'h20010005,32'h20020007,HALT_WORD} with i_enable=0, then enable -> o_instruccion 20010005,20020007,FC000000 on successive edges; o_halt=1 from third edge; o_pc stays 8.
REQ-032 Running, assert i_stall one cycle at PC=4 -> o_pc stays 4 and o_instruccion repeats for one extra cycle.
REQ-033 Running, i_jump_o_branch=1, i_pc_destino=32'h40 -> next edge o_pc=40, o_instruccion=0; following edge o_instruccion=mem[16].
REQ-034 i_stall=1 with i_jump_o_branch=1 -> PC unchanged; redirect taken only when stall drops.
REQ-035 Assert i_reset=0 mid-run between edges -> outputs reach reset values immediately without a clock edge; memory contents survive.
REQ-036 Loader write with i_enable=1 to index 0 -> mem[0] unchanged on later fetch.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package instruction_fetch_pkg;

   localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD    = 32'hFC00_0000;
   localparam int unsigned PC_INCREMENT = 4;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: one synchronous write port for the loader, one combinational read port.
module instruction_memory #(
   parameter int NB_DATA        = 32,
   parameter int NB_MEM_ADDRESS = 8
) (
   input  logic                      i_clock,
   input  logic                      i_write_enable,
   input  logic [NB_MEM_ADDRESS-1:0] i_write_address,
   input  logic [NB_DATA-1:0]        i_write_data,
   input  logic [NB_MEM_ADDRESS-1:0] i_read_address,
   output logic [NB_DATA-1:0]        o_read_data
);

   // No reset on the array: a loaded program must survive a reset.
   logic [NB_DATA-1:0] mem [2**NB_MEM_ADDRESS];

   always_ff @(posedge i_clock) begin
      if (i_write_enable) begin
         mem[i_write_address] <= i_write_data;
      end
   end

   assign o_read_data = mem[i_read_address];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, IF/ID pipeline register and RUN/HALTED control FSM.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int NB_DATA        = 32,
   parameter int NB_MEM_ADDRESS = 8
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_stall,
   input  logic                      i_jump_o_branch,
   input  logic [NB_DATA-1:0]        i_pc_destino,
   input  logic                      i_mem_write_enable,
   input  logic [NB_MEM_ADDRESS-1:0] i_mem_write_address,
   input  logic [NB_DATA-1:0]        i_mem_write_data,
   output logic [NB_DATA-1:0]        o_instruccion,
   output logic [NB_DATA-1:0]        o_pc_mas_4,
   output logic [NB_DATA-1:0]        o_pc,
   output logic                      o_halt,
   output fetch_state_t              o_fsm_state
);

   fetch_state_t        state, state_next;
   logic [NB_DATA-1:0]  pc, pc_next;
   logic [NB_DATA-1:0]  instr, instr_next;
   logic [NB_DATA-1:0]  pc4, pc4_next;
   logic [NB_DATA-1:0]  mem_rdata;
   logic [NB_DATA-1:0]  pc_plus;
   logic                advance;
   logic                fetched_halt;

   // Loader may only touch the memory while fetch is frozen, so read/write never collide.
   instruction_memory #(
      .NB_DATA        (NB_DATA),
      .NB_MEM_ADDRESS (NB_MEM_ADDRESS)
   ) u_imem (
      .i_clock         (i_clock),
      .i_write_enable  (i_mem_write_enable & ~i_enable),
      .i_write_address (i_mem_write_address),
      .i_write_data    (i_mem_write_data),
      .i_read_address  (pc[NB_MEM_ADDRESS+1:2]),
      .o_read_data     (mem_rdata)
   );

   assign pc_plus      = pc + NB_DATA'(PC_INCREMENT);
   assign advance      = i_enable && (state == ST_RUN) && !i_stall && !i_jump_o_branch;
   assign fetched_halt = (mem_rdata == NB_DATA'(HALT_WORD));

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (advance && fetched_halt) begin
         state_next = ST_HALTED;
      end
   end

   always_comb begin
      pc_next    = pc;
      instr_next = instr;
      pc4_next   = pc4;
      if (i_enable) begin
         if (state == ST_HALTED) begin
            // Feed bubbles so the captured HALT drains down the pipe.
            instr_next = NB_DATA'(NOP_WORD);
         end else if (i_stall) begin
            pc_next = pc;
         end else if (i_jump_o_branch) begin
            pc_next    = i_pc_destino;
            instr_next = NB_DATA'(NOP_WORD);
            pc4_next   = '0;
         end else begin
            instr_next = mem_rdata;
            pc4_next   = pc_plus;
            pc_next    = fetched_halt ? pc : pc_plus;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         pc    <= '0;
         instr <= NB_DATA'(NOP_WORD);
         pc4   <= '0;
      end else begin
         pc    <= pc_next;
         instr <= instr_next;
         pc4   <= pc4_next;
      end
   end

   assign o_pc          = pc;
   assign o_instruccion = instr;
   assign o_pc_mas_4    = pc4;
   assign o_halt        = (state == ST_HALTED);
   assign o_fsm_state   = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios then randomized traffic vs a reference model.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic         i_clock = 1'b0;
   logic         i_reset;
   logic         i_enable;
   logic         i_stall;
   logic         i_jump_o_branch;
   logic [31:0]  i_pc_destino;
   logic         i_mem_write_enable;
   logic [7:0]   i_mem_write_address;
   logic [31:0]  i_mem_write_data;
   logic [31:0]  o_instruccion;
   logic [31:0]  o_pc_mas_4;
   logic [31:0]  o_pc;
   logic         o_halt;
   fetch_state_t o_fsm_state;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: program image plus architectural view of the fetch stage.
   logic [31:0] model_mem [256];
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_halted;

   always #5 i_clock = ~i_clock;

   instruction_fetch #(.NB_DATA(32), .NB_MEM_ADDRESS(8)) dut (
      .i_clock             (i_clock),
      .i_reset             (i_reset),
      .i_enable            (i_enable),
      .i_stall             (i_stall),
      .i_jump_o_branch     (i_jump_o_branch),
      .i_pc_destino        (i_pc_destino),
      .i_mem_write_enable  (i_mem_write_enable),
      .i_mem_write_address (i_mem_write_address),
      .i_mem_write_data    (i_mem_write_data),
      .o_instruccion       (o_instruccion),
      .o_pc_mas_4          (o_pc_mas_4),
      .o_pc                (o_pc),
      .o_halt              (o_halt),
      .o_fsm_state         (o_fsm_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    o_pc,          m_pc);
      check({tag, ".instr"}, o_instruccion, m_instr);
      check({tag, ".pc4"},   o_pc_mas_4,    m_pc4);
      check({tag, ".halt"},  {31'd0, o_halt}, {31'd0, m_halted});
   endtask

   task automatic model_reset();
      m_pc = 0; m_instr = NOP_WORD; m_pc4 = 0; m_halted = 1'b0;
   endtask

   // Priority: frozen > halted > stall > redirect > sequential fetch.
   task automatic model_edge();
      logic [31:0] w;
      if (!i_reset) begin
         model_reset();
      end else if (!i_enable) begin
         if (i_mem_write_enable) model_mem[i_mem_write_address] = i_mem_write_data;
      end else if (m_halted) begin
         m_instr = NOP_WORD;
      end else if (i_stall) begin
         m_pc = m_pc;
      end else if (i_jump_o_branch) begin
         m_pc = i_pc_destino; m_instr = NOP_WORD; m_pc4 = 0;
      end else begin
         w       = model_mem[(m_pc / 4) % 256];
         m_instr = w;
         m_pc4   = m_pc + 4;
         if (w == HALT_WORD) m_halted = 1'b1;
         else                m_pc = m_pc + 4;
      end
   endtask

   task automatic step(input string tag);
      @(posedge i_clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      i_enable = 0; i_stall = 0; i_jump_o_branch = 0; i_pc_destino = 0;
      i_mem_write_enable = 0; i_mem_write_address = 0; i_mem_write_data = 0;
   endtask

   task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
      idle_inputs();
      i_mem_write_enable = 1; i_mem_write_address = idx; i_mem_write_data = data;
      step("load");
      i_mem_write_enable = 0;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT_WORD) w = w ^ 32'h1;
      return w;
   endfunction

   initial begin
      idle_inputs();
      i_reset = 0;
      model_reset();
      #2;
      check_all("reset_initial");
      @(negedge i_clock);
      i_reset = 1;

      for (int i = 0; i < 256; i++) load_word(8'(i), rand_word());
      load_word(8'd0,  32'h2001_0005);
      load_word(8'd1,  32'h2002_0007);
      load_word(8'd2,  HALT_WORD);
      load_word(8'd16, 32'h1234_5678);

      // Program run to HALT; loader write to index 0 while enabled must be dropped.
      idle_inputs();
      i_enable = 1;
      i_mem_write_enable = 1; i_mem_write_address = 0; i_mem_write_data = 32'hDEAD_BEEF;
      step("run1");
      check("run1.instr_const", o_instruccion, 32'h2001_0005);
      i_mem_write_enable = 0;
      step("run2");
      check("run2.instr_const", o_instruccion, 32'h2002_0007);
      step("run3");
      check("run3.instr_const", o_instruccion, 32'hFC00_0000);
      check("run3.halt_const", {31'd0, o_halt}, 32'd1);
      check("run3.pc_const", o_pc, 32'd8);
      i_stall = 1; i_jump_o_branch = 1; i_pc_destino = 32'h80;
      step("halted_ignore");
      check("halted.pc_const", o_pc, 32'd8);
      i_stall = 0; i_jump_o_branch = 0;
      step("halted_drain");

      // Asynchronous reset between edges.
      #2;
      i_reset = 0;
      model_reset();
      #1;
      check_all("async_reset");
      check("async_reset.pc_const", o_pc, 32'd0);
      @(negedge i_clock);
      i_reset = 1;
      load_word(8'd2, 32'h0022_1820);

      idle_inputs();
      i_enable = 1;
      step("post_reset_fetch0");
      check("mem0_survived", o_instruccion, 32'h2001_0005);
      i_stall = 1;
      step("stall_pc4");
      check("stall.pc_const", o_pc, 32'd4);
      i_stall = 0;
      step("after_stall");
      i_stall = 1; i_jump_o_branch = 1; i_pc_destino = 32'h40;
      step("stall_with_jump");
      check("stall_jump.pc_const", o_pc, 32'd8);
      i_stall = 0;
      step("jump_taken");
      check("jump.pc_const", o_pc, 32'h40);
      check("jump.instr_const", o_instruccion, 32'd0);
      i_jump_o_branch = 0;
      step("jump_target_fetch");
      check("jump_target.instr_const", o_instruccion, 32'h1234_5678);

      // Randomized traffic; HALT words are rare so most of the run stays live.
      for (int n = 0; n < 400; n++) begin
         i_enable            = ($urandom_range(0, 3) != 0);
         i_stall             = ($urandom_range(0, 4) == 0);
         i_jump_o_branch     = ($urandom_range(0, 5) == 0);
         i_pc_destino        = $urandom;
         i_mem_write_enable  = $urandom_range(0, 1);
         i_mem_write_address = 8'($urandom_range(0, 255));
         i_mem_write_data    = ($urandom_range(0, 99) == 0) ? HALT_WORD : rand_word();
         if (n == 200) begin
            i_reset = 0;
            #1;
            model_reset();
            check_all("rand_async_reset");
            i_reset = 1;
         end
         step("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
